// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller
//   Scans a 4x4 active-low matrix keypad, debounces presses and releases, and
//   drives the two-digit display history (new_digit -> prev_digit) with a
//   one-cycle en strobe per accepted key.
//
// Ports
//   int_osc     : sole clock, rising edge
//   reset       : asynchronous, active-low
//   col[3:0]    : keypad columns, active-low, asynchronous to int_osc
//   row[3:0]    : keypad row drive, active-low one-hot
//   new_digit   : hex code of the most recently accepted key
//   prev_digit  : hex code of the key accepted before that
//   en          : one-cycle strobe on each accepted key
//   key_held    : high while a key is accepted and not yet released
//
// Parameters
//   SCAN_DIV     : cycles each row is driven while scanning (>= 4)
//   DEBOUNCE_CNT : consecutive stable cycles to accept a press or a release
//   REPEAT_CNT   : hold cycles between auto-repeat strobes (>= 2)
//
// Optional feature
//   KEYPAD_AUTOREPEAT_EN : when defined, a held key re-emits en (and repeats
//   the digit shift) every REPEAT_CNT cycles. Undefined: one en per press.

module keypad_scan_controller #(
    parameter int SCAN_DIV     = 4096,
    parameter int DEBOUNCE_CNT = 20000,
    parameter int REPEAT_CNT   = 2000000
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] new_digit,
    output logic [3:0] prev_digit,
    output logic       en,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DW-1:0] DWELL_MAX    = DW'(SCAN_DIV - 1);
    // Two sync flops plus one cycle of margin after a row change.
    localparam logic [DW-1:0] DWELL_SAMPLE = DW'(3);
    localparam logic [CW-1:0] DEB_LAST     = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] DEB_MAX      = CW'(DEBOUNCE_CNT);

    // Nibble {r,c} holds the code of the key at row r / column c.
    localparam logic [63:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // A repeat period of 1 would strobe en on consecutive cycles.
    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 2) begin : g_bad_param
        $error("keypad_scan_controller: parameter out of range");
    end

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    col_s1, scol;
    logic [3:0]    row_nxt;
    logic [DW-1:0] dwell, dwell_nxt;
    logic [CW-1:0] deb, deb_nxt, deb_inc;
    logic [3:0]    pat, pat_nxt;
    logic [3:0]    new_nxt, prev_nxt;
    logic          en_nxt, held_nxt;
    logic          scol_valid, scol_idle;
    logic [1:0]    ridx, cidx;
    logic [3:0]    key_code;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CNT + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CNT - 1);
    logic [RW-1:0] rep, rep_nxt;
`endif

    // Exactly one low column is a press; none or several are ignored.
    always_comb begin
        scol_valid = 1'b0;
        case (scol)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: scol_valid = 1'b1;
            default:                            scol_valid = 1'b0;
        endcase
    end

    assign scol_idle = (scol == 4'b1111);
    assign deb_inc   = (deb == DEB_MAX) ? deb : deb + 1'b1;

    // Row is frozen from latch to acceptance, so it names the pressed row.
    always_comb begin
        ridx = 2'd0;
        case (row)
            4'b1101: ridx = 2'd1;
            4'b1011: ridx = 2'd2;
            4'b0111: ridx = 2'd3;
            default: ridx = 2'd0;
        endcase
        cidx = 2'd0;
        case (pat)
            4'b1101: cidx = 2'd1;
            4'b1011: cidx = 2'd2;
            4'b0111: cidx = 2'd3;
            default: cidx = 2'd0;
        endcase
        key_code = KEY_MAP[{ridx, cidx, 2'b00} +: 4];
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        dwell_nxt = dwell;
        deb_nxt   = deb;
        pat_nxt   = pat;
        new_nxt   = new_digit;
        prev_nxt  = prev_digit;
        en_nxt    = 1'b0;
        held_nxt  = key_held;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_nxt   = rep;
`endif
        case (state)
            SCAN: begin
                if (dwell >= DWELL_SAMPLE && scol_valid) begin
                    pat_nxt   = scol;
                    deb_nxt   = '0;
                    state_nxt = DEBOUNCE;
                end else if (dwell == DWELL_MAX) begin
                    dwell_nxt = '0;
                    row_nxt   = {row[2:0], row[3]};
                end else begin
                    dwell_nxt = dwell + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (scol != pat) begin
                    // Resume rotation from the frozen row with a fresh dwell.
                    dwell_nxt = '0;
                    state_nxt = SCAN;
                end else if (deb == DEB_LAST) begin
                    prev_nxt  = new_digit;
                    new_nxt   = key_code;
                    en_nxt    = 1'b1;
                    held_nxt  = 1'b1;
                    state_nxt = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_nxt   = '0;
`endif
                end else begin
                    deb_nxt = deb_inc;
                end
            end
            HELD: begin
                if (scol_idle) begin
                    deb_nxt   = '0;
                    state_nxt = RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_nxt   = '0;
                end else if (rep == REP_LAST) begin
                    // Repeat keeps the same code, so new_digit holds.
                    prev_nxt  = new_digit;
                    en_nxt    = 1'b1;
                    rep_nxt   = '0;
                end else begin
                    rep_nxt   = rep + 1'b1;
`endif
                end
            end
            RELEASE: begin
                if (!scol_idle) begin
                    state_nxt = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_nxt   = '0;
`endif
                end else if (deb == DEB_LAST) begin
                    held_nxt  = 1'b0;
                    row_nxt   = {row[2:0], row[3]};
                    dwell_nxt = '0;
                    state_nxt = SCAN;
                end else begin
                    deb_nxt = deb_inc;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            col_s1     <= 4'b1111;
            scol       <= 4'b1111;
            state      <= SCAN;
            row        <= 4'b1110;
            dwell      <= '0;
            deb        <= '0;
            pat        <= 4'b1111;
            new_digit  <= 4'h0;
            prev_digit <= 4'h0;
            en         <= 1'b0;
            key_held   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep        <= '0;
`endif
        end else begin
            col_s1     <= col;
            scol       <= col_s1;
            state      <= state_nxt;
            row        <= row_nxt;
            dwell      <= dwell_nxt;
            deb        <= deb_nxt;
            pat        <= pat_nxt;
            new_digit  <= new_nxt;
            prev_digit <= prev_nxt;
            en         <= en_nxt;
            key_held   <= held_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep        <= rep_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Testbench for keypad_scan_controller (SCAN_DIV=8, DEBOUNCE_CNT=16,
// REPEAT_CNT=32). A keypad matrix model turns the set of pressed keys into
// col from the driven row. A scoreboard of expected key codes drives a
// per-cycle check of en, digits and row; directed steps pin literal values.

module tb_keypad_scan_controller;

    localparam int SD = 8;
    localparam int DB = 16;
    localparam int RP = 32;

    logic        int_osc = 1'b0;
    logic        reset   = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  new_digit;
    logic [3:0]  prev_digit;
    logic        en;
    logic        key_held;

    logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;

    logic [3:0]  exp_q[$];
    logic [3:0]  m_new   = 4'h0;
    logic [3:0]  m_prev  = 4'h0;
    logic        prev_en = 1'b0;
    int          last_en = -1000;

    keypad_scan_controller #(
        .SCAN_DIV    (SD),
        .DEBOUNCE_CNT(DB),
        .REPEAT_CNT  (RP)
    ) dut (
        .int_osc   (int_osc),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .new_digit (new_digit),
        .prev_digit(prev_digit),
        .en        (en),
        .key_held  (key_held)
    );

    always #5 int_osc = ~int_osc;
    always @(posedge int_osc) cyc <= cyc + 1;

    // Passive matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Per-cycle comparison against the scoreboard model.
    always @(negedge int_osc) begin
        if (!reset) begin
            m_new   = 4'h0;
            m_prev  = 4'h0;
            prev_en = 1'b0;
            last_en = -1000;
            exp_q.delete();
        end else begin
            chk("row_onehot", int'(row == 4'b1110 || row == 4'b1101 ||
                                   row == 4'b1011 || row == 4'b0111), 1);
            if (en) begin
                chk("en_not_consecutive", int'(prev_en), 0);
                chk("held_with_en", int'(key_held), 1);
                chk("en_expected", int'(exp_q.size() > 0), 1);
`ifndef KEYPAD_AUTOREPEAT_EN
                chk("en_spacing", int'(cyc - last_en >= 2*DB + 1), 1);
`endif
                if (exp_q.size() > 0) begin
                    m_prev = m_new;
                    m_new  = exp_q.pop_front();
                end
                last_en = cyc;
            end
            chk("new_digit", new_digit, m_new);
            chk("prev_digit", prev_digit, m_prev);
            prev_en = en;
        end
    end

    task automatic wait_en(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound && at < 0; i++) begin
            @(negedge int_osc);
            if (en) at = cyc;
        end
        chk("en_within_bound", int'(at >= 0), 1);
    endtask

    task automatic wait_row(input logic [3:0] pat, input int bound, output int at);
        int i;
        i = 0;
        while (row == pat && i < bound) begin @(negedge int_osc); i++; end
        while (row != pat && i < bound) begin @(negedge int_osc); i++; end
        at = (row == pat) ? cyc : -1;
        chk("row_reached", int'(row == pat), 1);
    endtask

    task automatic wait_release(input int bound);
        int i;
        i = 0;
        while (key_held && i < bound) begin @(negedge int_osc); i++; end
        chk("key_released", int'(key_held), 0);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int a, b, x, lastc;
        logic [3:0] lastr;

        #1 reset = 1'b0;
        repeat (3) @(negedge int_osc);
        chk("reset_row", row, 4'b1110);
        chk("reset_new", new_digit, 0);
        chk("reset_prev", prev_digit, 0);
        chk("reset_en", en, 0);
        chk("reset_held", key_held, 0);
        reset = 1'b1;

        // Single press: key 8 (row 2, col 1).
        exp_q.push_back(4'h8);
        pressed[9] = 1'b1;
        wait_row(4'b1011, 60, x);
        wait_en(60, a);
        chk("latency_max", int'(a - x <= 2 + SD + 3 + DB + 1), 1);
        chk("latency_min", int'(a - x >= 2 + DB + 1), 1);
        chk("press8_new", new_digit, 4'h8);
        chk("press8_prev", prev_digit, 4'h0);
        chk("press8_held", key_held, 1);
        @(negedge int_osc);
        chk("en_one_cycle", en, 0);
        pressed = '0;
        wait_release(60);
        chk("row_resume", row, 4'b0111);

        // History: 5 then 0.
        exp_q.push_back(4'h5);
        pressed[5] = 1'b1;
        wait_en(100, a);
        pressed = '0;
        wait_release(60);
        exp_q.push_back(4'h0);
        pressed[13] = 1'b1;
        wait_en(100, a);
        chk("hist_new", new_digit, 4'h0);
        chk("hist_prev", prev_digit, 4'h5);
        pressed = '0;
        wait_release(60);

        // Press bounce on key 7 (col 0), 5-cycle toggles.
        for (int t = 0; t < 16; t++) begin
            pressed[8] = ~pressed[8];
            repeat (5) @(negedge int_osc);
        end
        pressed = '0;
        repeat (20) @(negedge int_osc);
        chk("bounce_new", new_digit, 4'h0);
        chk("bounce_prev", prev_digit, 4'h5);

        // Release bounce on key 3: 10 cycles up, then down again.
        exp_q.push_back(4'h3);
        pressed[2] = 1'b1;
        wait_en(100, a);
        repeat (3) @(negedge int_osc);
        pressed[2] = 1'b0;
        repeat (10) @(negedge int_osc);
        pressed[2] = 1'b1;
        repeat (20) @(negedge int_osc);
        chk("relbounce_held", key_held, 1);
        chk("relbounce_new", new_digit, 4'h3);
        pressed = '0;
        wait_release(60);

        // Two keys in one row (col 1001) are never accepted.
        pressed[1] = 1'b1;
        pressed[2] = 1'b1;
        repeat (60) @(negedge int_osc);
        chk("multikey_new", new_digit, 4'h3);
        chk("multikey_held", key_held, 0);
        pressed = '0;
        repeat (5) @(negedge int_osc);

        // Hold key 1, then add key 2: ignored.
        exp_q.push_back(4'h1);
        pressed[0] = 1'b1;
        wait_en(100, a);
        pressed[1] = 1'b1;
        repeat (20) @(negedge int_osc);
        chk("ignore_new", new_digit, 4'h1);
        chk("ignore_prev", prev_digit, 4'h3);
        chk("ignore_held", key_held, 1);
        pressed = '0;
        wait_release(60);

        // Long hold of key A.
`ifdef KEYPAD_AUTOREPEAT_EN
        repeat (4) exp_q.push_back(4'hA);
        pressed[3] = 1'b1;
        wait_en(100, a);
        for (int k = 1; k <= 3; k++) begin
            wait_en(40, b);
            chk("repeat_period", b - a, RP * k);
        end
        chk("repeat_new", new_digit, 4'hA);
        chk("repeat_prev", prev_digit, 4'hA);
        repeat (4) @(negedge int_osc);
`else
        exp_q.push_back(4'hA);
        pressed[3] = 1'b1;
        wait_en(100, a);
        repeat (100) @(negedge int_osc);
        chk("hold_new", new_digit, 4'hA);
        chk("hold_prev", prev_digit, 4'h1);
`endif
        pressed = '0;
        wait_release(60);

        // Reset mid-DEBOUNCE on key 9, then idle scanning.
        pressed[10] = 1'b1;
        wait_row(4'b1011, 60, x);
        repeat (10) @(negedge int_osc);
        @(posedge int_osc);
        #2 reset = 1'b0;
        #1;
        chk("midrst_row", row, 4'b1110);
        chk("midrst_new", new_digit, 0);
        chk("midrst_prev", prev_digit, 0);
        chk("midrst_en", en, 0);
        chk("midrst_held", key_held, 0);
        pressed = '0;
        repeat (3) @(negedge int_osc);
        reset = 1'b1;
        lastr = row;
        lastc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge int_osc);
            if (row != lastr) begin
                chk("rot_order", row, {lastr[2:0], lastr[3]});
                if (lastc >= 0) chk("rot_dwell", cyc - lastc, SD);
                lastc = cyc;
                lastr = row;
            end
        end
        chk("rot_seen", int'(lastc >= 0), 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
